// File: rtl/elastic_pipe_reg_pkg.sv
// Sizing helpers and per-stage state type for the elastic pipeline register.
// VC_ELASTIC_PIPE_SKID_EN doubles capacity (two entries per stage).
package vc_pipe_pkg;

    typedef struct packed {
        logic val;
        logic skid_val;
    } stage_state_t;

    function automatic int cap(input int nstages);
`ifdef VC_ELASTIC_PIPE_SKID_EN
        return 2 * nstages;
`else
        return nstages;
`endif
    endfunction

    function automatic int cnt_w(input int nstages);
        return $clog2(cap(nstages) + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One elastic stage with val/rdy on both sides; flush clears valid bits, data holds.
// With VC_ELASTIC_PIPE_SKID_EN a second entry makes in_rdy_o a pure flop output.
module elastic_pipe_stage
    import vc_pipe_pkg::*;
#(
    parameter int                 p_nbits       = 32,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               in_val_i,
    output logic               in_rdy_o,
    input  logic [p_nbits-1:0] in_msg_i,
    output logic               out_val_o,
    input  logic               out_rdy_i,
    output logic [p_nbits-1:0] out_msg_o
);

    stage_state_t       st_q, st_d;
    logic [p_nbits-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= '0;
            data_q <= p_reset_value;
        end else begin
            st_q   <= st_d;
            data_q <= data_d;
        end
    end

    assign out_val_o = st_q.val;
    assign out_msg_o = data_q;

`ifdef VC_ELASTIC_PIPE_SKID_EN
    logic [p_nbits-1:0] skid_q, skid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) skid_q <= p_reset_value;
        else     skid_q <= skid_d;
    end

    assign in_rdy_o = !st_q.skid_val;

    // Main entry refills from the skid entry first so order is preserved.
    always_comb begin
        st_d   = st_q;
        data_d = data_q;
        skid_d = skid_q;
        if (flush_i) begin
            st_d = '0;
        end else if (!st_q.val || out_rdy_i) begin
            if (st_q.skid_val) begin
                data_d        = skid_q;
                st_d.val      = 1'b1;
                st_d.skid_val = 1'b0;
            end else begin
                st_d.val = in_val_i;
                if (in_val_i) data_d = in_msg_i;
            end
        end else if (in_val_i && !st_q.skid_val) begin
            skid_d        = in_msg_i;
            st_d.skid_val = 1'b1;
        end
    end
`else
    assign in_rdy_o = !st_q.skid_val && (!st_q.val || out_rdy_i);

    always_comb begin
        st_d   = st_q;
        data_d = data_q;
        if (flush_i) begin
            st_d = '0;
        end else if (!st_q.val || out_rdy_i) begin
            st_d.val = in_val_i;
            if (in_val_i) data_d = in_msg_i;
        end
    end
`endif

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: p_nstages val/rdy stages with flush and occupancy count.
// Define VC_ELASTIC_PIPE_SKID_EN for registered-ready skid stages (capacity 2*p_nstages).
module elastic_pipe_reg
    import vc_pipe_pkg::*;
#(
    parameter int                 p_nbits       = 32,
    parameter int                 p_nstages     = 2,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [p_nbits-1:0]          in_msg,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [p_nbits-1:0]          out_msg,
    output logic [cnt_w(p_nstages)-1:0] occupancy
);

    localparam int CAP   = cap(p_nstages);
    localparam int CNT_W = cnt_w(p_nstages);

    if (p_nstages < 1) begin : g_bad_depth
        $error("elastic_pipe_reg: p_nstages must be >= 1");
    end

    logic [p_nstages:0] val_c;
    logic [p_nstages:0] rdy_c;
    logic [p_nbits-1:0] msg_c [0:p_nstages];
    logic               in_fire, out_fire;
    logic [CNT_W-1:0]   occ_q, occ_d;

    assign val_c[0]         = in_val;
    assign msg_c[0]         = in_msg;
    assign rdy_c[p_nstages] = out_rdy;

    for (genvar i = 0; i < p_nstages; i++) begin : g_stage
        elastic_pipe_stage #(
            .p_nbits       (p_nbits),
            .p_reset_value (p_reset_value)
        ) u_stage (
            .clk       (clk),
            .rst       (reset),
            .flush_i   (flush),
            .in_val_i  (val_c[i]),
            .in_rdy_o  (rdy_c[i]),
            .in_msg_i  (msg_c[i]),
            .out_val_o (val_c[i+1]),
            .out_rdy_i (rdy_c[i+1]),
            .out_msg_o (msg_c[i+1])
        );
    end

    // Flush and reset mask the external handshake so no transfer is counted.
    assign in_rdy    = rdy_c[0] && !flush && !reset;
    assign out_val   = val_c[p_nstages] && !flush;
    assign out_msg   = msg_c[p_nstages];
    assign in_fire   = in_val && in_rdy;
    assign out_fire  = out_val && out_rdy;
    assign occupancy = occ_q;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (out_fire && !in_fire) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) occ_q <= '0;
        else       occ_q <= occ_d;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown({in_val, out_rdy, flush}))
                else $error("elastic_pipe_reg: X on in_val/out_rdy/flush");
            assert (!(in_fire && !out_fire && occ_q == CNT_W'(CAP)))
                else $error("elastic_pipe_reg: occupancy overflow");
            assert (!(out_fire && !in_fire && occ_q == '0))
                else $error("elastic_pipe_reg: occupancy underflow");
        end
    end
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Self-checking bench for elastic_pipe_reg (p_nstages=3) with a queue-based reference model.
// Exact handshake prediction in the default build; ordering/occupancy checks with VC_ELASTIC_PIPE_SKID_EN.
module tb_elastic_pipe_reg;

    localparam int NB = 32;
    localparam int NS = 3;
    localparam logic [NB-1:0] RV = 32'hDEAD_BEEF;
`ifdef VC_ELASTIC_PIPE_SKID_EN
    localparam int CAP = 2 * NS;
`else
    localparam int CAP = NS;
`endif
    localparam int CW = $clog2(CAP + 1);

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          flush   = 1'b0;
    logic          in_val  = 1'b0;
    logic          out_rdy = 1'b0;
    logic [NB-1:0] in_msg  = '0;
    logic          in_rdy, out_val;
    logic [NB-1:0] out_msg;
    logic [CW-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    // Reference model: messages oldest-first, each with the stage index it occupies.
    logic [NB-1:0] mq[$];
    int            mpos[$];
    logic [NB-1:0] m_last = RV;

    always #5 clk = ~clk;

    elastic_pipe_reg #(
        .p_nbits       (NB),
        .p_nstages     (NS),
        .p_reset_value (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_msg    (in_msg),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg),
        .occupancy (occupancy)
    );

    function automatic logic exp_in_rdy();
        return !reset && !flush && !(mq.size() == CAP && !out_rdy);
    endfunction

    function automatic logic exp_out_val();
        return !reset && !flush && mq.size() > 0 && mpos[0] == NS - 1;
    endfunction

    // Advance one clock edge: DUT and model both move; called from just after a negedge.
    task automatic step();
        logic in_f, out_f;
        int   lim;
        #1;
`ifdef VC_ELASTIC_PIPE_SKID_EN
        in_f  = in_val && in_rdy;
        out_f = out_val && out_rdy;
`else
        in_f  = in_val && exp_in_rdy();
        out_f = exp_out_val() && out_rdy;
`endif
        @(posedge clk);
        if (flush) begin
            mq.delete();
            mpos.delete();
        end else begin
            if (out_f) begin
                void'(mq.pop_front());
                void'(mpos.pop_front());
            end
            for (int k = 0; k < mpos.size(); k++) begin
                lim     = (k == 0) ? NS - 1 : mpos[k-1] - 1;
                mpos[k] = (mpos[k] + 1 < lim) ? mpos[k] + 1 : lim;
            end
            if (in_f) begin
                mq.push_back(in_msg);
                mpos.push_back(0);
            end
            if (mpos.size() > 0 && mpos[0] == NS - 1) m_last = mq[0];
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got %0b want 0", out_val); end
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy got %0b want 0", in_rdy); end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if (out_msg !== RV) begin errors++; $display("FAIL reset_out_msg got %h want %h", out_msg, RV); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_release_in_rdy got %0b want 1", in_rdy); end
        @(negedge clk);
    endtask

    task automatic test_stream();
        int first_cyc, n_out, gap_err;
        logic [NB-1:0] want;
        first_cyc = -1; n_out = 0; gap_err = 0;
        out_rdy = 1'b1;
        flush   = 1'b0;
        for (int c = 0; c < 16; c++) begin
            in_val = (c < 8);
            in_msg = 32'(c + 1);
            #1;
            checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL stream_in_rdy cyc %0d got %0b want 1", c, in_rdy); end
            if (out_val === 1'b1) begin
                if (first_cyc < 0) first_cyc = c;
                want = 32'(n_out + 1);
                checks++; if (out_msg !== want) begin errors++; $display("FAIL stream_data got %h want %h", out_msg, want); end
                if (c != first_cyc + n_out) gap_err++;
                n_out++;
            end
            step();
        end
        in_val = 1'b0;
        checks++; if (first_cyc != 3) begin errors++; $display("FAIL stream_latency got %0d want 3", first_cyc); end
        checks++; if (n_out != 8) begin errors++; $display("FAIL stream_count got %0d want 8", n_out); end
        checks++; if (gap_err != 0) begin errors++; $display("FAIL stream_bubbles got %0d want 0", gap_err); end
    endtask

    task automatic test_full_stall();
        int sent, got, order_err;
        logic hit;
        sent = 0; got = 0; order_err = 0; hit = 1'b0;
        out_rdy = 1'b0;
        for (int c = 0; c < 4 * CAP + 4; c++) begin
            in_val = 1'b1;
            in_msg = 32'h100 + 32'(sent);
            #1;
            if (in_rdy !== 1'b1) begin
                hit = 1'b1;
                break;
            end
            sent++;
            step();
        end
        in_val = 1'b0;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL stall_in_rdy_drop got %0b want 1", hit); end
        checks++; if (sent != CAP) begin errors++; $display("FAIL stall_accepted got %0d want %0d", sent, CAP); end
        checks++; if (occupancy !== CW'(CAP)) begin errors++; $display("FAIL stall_occupancy got %0d want %0d", occupancy, CAP); end
        out_rdy = 1'b1;
`ifndef VC_ELASTIC_PIPE_SKID_EN
        #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL stall_release_in_rdy got %0b want 1", in_rdy); end
`endif
        for (int c = 0; c < 4 * CAP + 8; c++) begin
            #1;
            if (out_val === 1'b1) begin
                if (out_msg !== 32'h100 + 32'(got)) order_err++;
                got++;
            end
            step();
        end
        checks++; if (got != CAP) begin errors++; $display("FAIL stall_drain_count got %0d want %0d", got, CAP); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL stall_drain_order got %0d want 0", order_err); end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL stall_drain_occupancy got %0d want 0", occupancy); end
    endtask

    task automatic test_bubble();
        out_rdy = 1'b0;
        in_val  = 1'b1; in_msg = 32'h0000_00A0; step();
        in_val  = 1'b0; step(); step();
        in_val  = 1'b1; in_msg = 32'h0000_00B0; step();
        in_val  = 1'b0; repeat (3) step();
        #1;
        checks++; if (occupancy !== CW'(2)) begin errors++; $display("FAIL bubble_occupancy got %0d want 2", occupancy); end
        out_rdy = 1'b1;
        #1;
        checks++; if (out_val !== 1'b1 || out_msg !== 32'h0000_00A0) begin errors++; $display("FAIL bubble_first got %0b/%h want 1/000000a0", out_val, out_msg); end
        step();
        #1;
        checks++; if (out_val !== 1'b1 || out_msg !== 32'h0000_00B0) begin errors++; $display("FAIL bubble_second got %0b/%h want 1/000000b0", out_val, out_msg); end
        step();
        #1;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL bubble_empty got %0b want 0", out_val); end
        step();
    endtask

    task automatic test_flush();
        int edges;
        out_rdy = 1'b0;
        in_val  = 1'b1; in_msg = 32'h0000_00A1; step();
        in_msg  = 32'h0000_00A2; step();
        in_val  = 1'b0;
        #1;
        checks++; if (occupancy !== CW'(2)) begin errors++; $display("FAIL flush_pre_occupancy got %0d want 2", occupancy); end
        flush  = 1'b1;
        in_val = 1'b1; in_msg = 32'h0000_0BAD;
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL flush_in_rdy got %0b want 0", in_rdy); end
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL flush_out_val got %0b want 0", out_val); end
        step();
        flush   = 1'b0;
        in_val  = 1'b1; in_msg = 32'h0000_000C;
        out_rdy = 1'b1;
        #1;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL flush_after_out_val got %0b want 0", out_val); end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL flush_after_occupancy got %0d want 0", occupancy); end
        step();
        in_val = 1'b0;
        edges  = 1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_val === 1'b1) break;
            step();
            edges++;
        end
        checks++; if (edges != NS) begin errors++; $display("FAIL flush_next_latency got %0d want %0d", edges, NS); end
        checks++; if (out_msg !== 32'h0000_000C) begin errors++; $display("FAIL flush_next_data got %h want 0000000c", out_msg); end
        step();
        #1;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got %0b want 0", out_val); end
        step();
    endtask

    task automatic test_reset_midstream();
        int emerged;
        emerged = 0;
        out_rdy = 1'b1;
        in_val  = 1'b1; in_msg = 32'h0000_0E01; step();
        in_msg  = 32'h0000_0E02; step();
        in_val  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL midreset_out_val got %0b want 0", out_val); end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL midreset_occupancy got %0d want 0", occupancy); end
        checks++; if (out_msg !== RV) begin errors++; $display("FAIL midreset_out_msg got %h want %h", out_msg, RV); end
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL midreset_in_rdy got %0b want 0", in_rdy); end
        @(posedge clk);
        @(negedge clk);
        mq.delete();
        mpos.delete();
        m_last = RV;
        reset  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_val === 1'b1) emerged++;
            step();
        end
        checks++; if (emerged != 0) begin errors++; $display("FAIL midreset_emerged got %0d want 0", emerged); end
    endtask

    task automatic test_random(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            in_val  = ($urandom_range(99) < 70);
            out_rdy = (c < ncyc / 2) ? ($urandom_range(99) < 35) : ($urandom_range(99) < 75);
            flush   = ($urandom_range(63) == 0);
            in_msg  = $urandom;
            #1;
            checks++; if (occupancy !== CW'(mq.size())) begin errors++; $display("FAIL rand_occupancy cyc %0d got %0d want %0d", c, occupancy, mq.size()); end
`ifdef VC_ELASTIC_PIPE_SKID_EN
            checks++; if (out_val === 1'b1 && (mq.size() == 0 || out_msg !== mq[0])) begin errors++; $display("FAIL rand_head cyc %0d got %h want queue head", c, out_msg); end
            checks++; if (mq.size() == CAP && in_rdy !== 1'b0) begin errors++; $display("FAIL rand_full_in_rdy cyc %0d got %0b want 0", c, in_rdy); end
`else
            checks++; if (in_rdy !== exp_in_rdy()) begin errors++; $display("FAIL rand_in_rdy cyc %0d got %0b want %0b", c, in_rdy, exp_in_rdy()); end
            checks++; if (out_val !== exp_out_val()) begin errors++; $display("FAIL rand_out_val cyc %0d got %0b want %0b", c, out_val, exp_out_val()); end
            checks++; if (out_msg !== m_last) begin errors++; $display("FAIL rand_out_msg cyc %0d got %h want %h", c, out_msg, m_last); end
`endif
            step();
        end
        flush   = 1'b0;
        in_val  = 1'b0;
        out_rdy = 1'b1;
        repeat (3 * CAP + 2) step();
        #1;
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL rand_drain_occupancy got %0d want 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_stall();
        test_bubble();
        test_flush();
        test_reset_midstream();
        test_random(10000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
